// File: rtl/div_sequencer_if.sv
// Request/response bundle between a DIV issuer and the div_sequencer.
// The issuer uses the master modport; the sequencer uses the slave modport.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic             op_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] hi_out;
    logic             div_by_zero;

    modport master (
        output start_valid, op_signed, dividend, divisor, res_ready,
        input  start_ready, res_valid, lo_out, hi_out, div_by_zero
    );

    modport slave (
        input  start_valid, op_signed, dividend, divisor, res_ready,
        output start_ready, res_valid, lo_out, hi_out, div_by_zero
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle wrapper around a combinational unsigned divider: feeds it operand
// magnitudes, waits a fixed settle window, then sign-corrects quotient/remainder.
module div_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned WIDTH         = 32
) (
    input  logic             clk,
    input  logic             reset,
    div_sequencer_if.slave   bus,
    output logic [WIDTH-1:0] div_q,
    output logic [WIDTH-1:0] div_m,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        FIX,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [3:0]       counter, counter_next;
    logic             neg_q, neg_q_next;
    logic             neg_r, neg_r_next;
    logic [WIDTH-1:0] div_q_next, div_m_next;
    logic [WIDTH-1:0] lo, lo_next;
    logic [WIDTH-1:0] hi, hi_next;
    logic             dbz, dbz_next;
    logic [WIDTH-1:0] mag_dividend, mag_divisor;

    // Magnitudes are only taken for signed ops; |0x80000000| stays 0x80000000.
    assign mag_dividend = (bus.op_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign mag_divisor  = (bus.op_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div_q   <= '0;
            div_m   <= '0;
            lo      <= '0;
            hi      <= '0;
            dbz     <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            neg_q   <= neg_q_next;
            neg_r   <= neg_r_next;
            div_q   <= div_q_next;
            div_m   <= div_m_next;
            lo      <= lo_next;
            hi      <= hi_next;
            dbz     <= dbz_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        neg_q_next   = neg_q;
        neg_r_next   = neg_r;
        div_q_next   = div_q;
        div_m_next   = div_m;
        lo_next      = lo;
        hi_next      = hi;
        dbz_next     = dbz;

        case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    div_q_next = mag_dividend;
                    div_m_next = mag_divisor;
                    neg_q_next = bus.op_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    neg_r_next = bus.op_signed & bus.dividend[WIDTH-1];
                    if (bus.divisor == '0) begin
                        // Divide by zero bypasses the divider entirely.
                        lo_next    = '1;
                        hi_next    = bus.dividend;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        counter_next = 4'(SETTLE_CYCLES - 1);
                        dbz_next     = 1'b0;
                        state_next   = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (counter == 4'd0) begin
                    state_next = FIX;
                end else begin
                    counter_next = counter - 4'd1;
                end
            end
            FIX: begin
                lo_next    = neg_q ? -div_quotient  : div_quotient;
                hi_next    = neg_r ? -div_remainder : div_remainder;
                state_next = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.res_valid   = (state == DONE);
    assign bus.lo_out      = lo;
    assign bus.hi_out      = hi;
    assign bus.div_by_zero = dbz;

endmodule
